// File: rtl/dual_port_ram_arb_if.sv
// Request/ready port bundle for dual_port_ram_arb.
// One instance per RAM port; the RAM uses the slave modport.
interface dual_port_ram_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                      req;
    logic                      we;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [ADDR_WIDTH-1:0]     addr;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      ready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic                      rvalid;

    modport master (
        output req, we, be, addr, wdata,
        input  ready, rdata, rvalid
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output ready, rdata, rvalid
    );
endinterface

// File: rtl/dual_port_ram_arb.sv
// Two-port byte-writable RAM with round-robin arbitration of same-word conflicts.
// Optional MEM_COLLISION_CNT_EN adds a saturating 16-bit conflict counter port.
module dual_port_ram_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int OUT_REG    = 0
) (
    input  logic               clock,
    input  logic               reset,
    dual_port_ram_arb_if.slave port_a,
    dual_port_ram_arb_if.slave port_b
`ifdef MEM_COLLISION_CNT_EN
    ,
    output logic [15:0]        collision_cnt
`endif
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);

    logic [IW-1:0] idx_a;
    logic [IW-1:0] idx_b;
    logic          conflict;
    logic          acc_a;
    logic          acc_b;
    logic          wr_a;
    logic          wr_b;
    logic          rd_a;
    logic          rd_b;

    logic          prio_q;
    logic          prio_d;

    logic                  rv1_a_q, rv1_a_d;
    logic                  rv1_b_q, rv1_b_d;
    logic [DATA_WIDTH-1:0] rd1_a_q, rd1_a_d;
    logic [DATA_WIDTH-1:0] rd1_b_q, rd1_b_d;
    logic                  rv2_a_q, rv2_a_d;
    logic                  rv2_b_q, rv2_b_d;
    logic [DATA_WIDTH-1:0] rd2_a_q, rd2_a_d;
    logic [DATA_WIDTH-1:0] rd2_b_q, rd2_b_d;

    // Power-up contents are zero; reset never touches the array.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

    assign idx_a = IW'(port_a.addr % DEPTH_A);
    assign idx_b = IW'(port_b.addr % DEPTH_A);

    assign conflict = port_a.req && port_b.req
                    && (idx_a == idx_b)
                    && (port_a.we || port_b.we);

    // The port not pointed to by prio stalls only on a real conflict.
    assign port_a.ready = reset && !(conflict && prio_q);
    assign port_b.ready = reset && !(conflict && !prio_q);

    assign acc_a = port_a.req && port_a.ready;
    assign acc_b = port_b.req && port_b.ready;
    assign wr_a  = acc_a && port_a.we;
    assign wr_b  = acc_b && port_b.we;
    assign rd_a  = acc_a && !port_a.we;
    assign rd_b  = acc_b && !port_b.we;

    always_ff @(posedge clock) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_a && port_a.be[b]) begin
                mem_q[idx_a][b*8 +: 8] <= port_a.wdata[b*8 +: 8];
            end
            if (wr_b && port_b.be[b]) begin
                mem_q[idx_b][b*8 +: 8] <= port_b.wdata[b*8 +: 8];
            end
        end
    end

    always_comb begin
        prio_d  = prio_q ^ conflict;
        rv1_a_d = rd_a;
        rv1_b_d = rd_b;
        rd1_a_d = rd1_a_q;
        rd1_b_d = rd1_b_q;
        if (rd_a) begin
            rd1_a_d = mem_q[idx_a];
        end
        if (rd_b) begin
            rd1_b_d = mem_q[idx_b];
        end
        rv2_a_d = rv1_a_q;
        rv2_b_d = rv1_b_q;
        rd2_a_d = rv1_a_q ? rd1_a_q : rd2_a_q;
        rd2_b_d = rv1_b_q ? rd1_b_q : rd2_b_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prio_q  <= 1'b0;
            rv1_a_q <= 1'b0;
            rv1_b_q <= 1'b0;
            rd1_a_q <= '0;
            rd1_b_q <= '0;
            rv2_a_q <= 1'b0;
            rv2_b_q <= 1'b0;
            rd2_a_q <= '0;
            rd2_b_q <= '0;
        end else begin
            prio_q  <= prio_d;
            rv1_a_q <= rv1_a_d;
            rv1_b_q <= rv1_b_d;
            rd1_a_q <= rd1_a_d;
            rd1_b_q <= rd1_b_d;
            rv2_a_q <= rv2_a_d;
            rv2_b_q <= rv2_b_d;
            rd2_a_q <= rd2_a_d;
            rd2_b_q <= rd2_b_d;
        end
    end

    assign port_a.rvalid = (OUT_REG != 0) ? rv2_a_q : rv1_a_q;
    assign port_b.rvalid = (OUT_REG != 0) ? rv2_b_q : rv1_b_q;
    assign port_a.rdata  = (OUT_REG != 0) ? rd2_a_q : rd1_a_q;
    assign port_b.rdata  = (OUT_REG != 0) ? rd2_b_q : rd1_b_q;

`ifdef MEM_COLLISION_CNT_EN
    logic [15:0] coll_q;
    logic [15:0] coll_d;

    always_comb begin
        coll_d = coll_q;
        if (conflict && (coll_q != 16'hFFFF)) begin
            coll_d = coll_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            coll_q <= '0;
        end else begin
            coll_q <= coll_d;
        end
    end

    assign collision_cnt = coll_q;
`endif
endmodule
